// File: rtl/spi_mpu_burst.sv
// Burst SPI master (mode 3) for the MPU: header {rw, addr} followed by 1..2^LEN_W-1 data bytes.
// Write support is built only with SPI_MPU_WRITE_EN defined; otherwise every transaction is a read.
//
// state | meaning
// idle  | bus released, waiting for start
// setup | cs_n low, sclk high for CLK_DIV cycles before the first bit
// shift | clocking bytes, 2*CLK_DIV cycles per bit
// hold  | last bit done, cs_n held low for CLK_DIV cycles
module spi_mpu_burst #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wdata,
  input  logic             miso,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  output logic             busy,
  output logic             finish,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             wdata_req
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             phase_hi;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] byte_idx;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             rx_done;
  logic             is_read;
  logic [7:0]       header;
  logic [7:0]       next_byte;

`ifdef SPI_MPU_WRITE_EN
  logic rw_q;
  assign is_read   = rw_q;
  assign header    = {rw, addr};
  assign next_byte = rw_q ? 8'hFF : wdata;
`else
  logic unused_inputs;
  assign unused_inputs = ^{rw, wdata};
  assign is_read   = 1'b1;
  assign header    = {1'b1, addr};
  assign next_byte = 8'hFF;
  assign wdata_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      phase_hi    <= 1'b0;
      bit_cnt     <= 3'd0;
      byte_idx    <= '0;
      len_q       <= '0;
      tx_sr       <= 8'hFF;
      rx_sr       <= 8'h00;
      rx_done     <= 1'b0;
      sclk        <= 1'b1;
      cs_n        <= 1'b1;
      mosi        <= 1'b1;
      busy        <= 1'b0;
      finish      <= 1'b0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
`ifdef SPI_MPU_WRITE_EN
      rw_q        <= 1'b0;
      wdata_req   <= 1'b0;
`endif
    end else begin
      finish      <= 1'b0;
      rdata_valid <= 1'b0;
      rx_done     <= 1'b0;
`ifdef SPI_MPU_WRITE_EN
      wdata_req   <= 1'b0;
`endif
      // received byte is published one cycle after its last sample
      if (rx_done) begin
        rdata       <= rx_sr;
        rdata_valid <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          // finish still high means the previous transaction has only just ended
          if (start && !finish) begin
            len_q    <= (len == '0) ? LEN_W'(1) : len;
            tx_sr    <= header;
            byte_idx <= '0;
            bit_cnt  <= 3'd0;
            cnt      <= CNT_LOAD;
            busy     <= 1'b1;
            cs_n     <= 1'b0;
            state    <= ST_SETUP;
`ifdef SPI_MPU_WRITE_EN
            rw_q     <= rw;
`endif
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            sclk     <= 1'b0;
            mosi     <= tx_sr[7];
            phase_hi <= 1'b0;
            cnt      <= CNT_LOAD;
            state    <= ST_SHIFT;
`ifdef SPI_MPU_WRITE_EN
            wdata_req <= !rw_q;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= CNT_LOAD;
            if (!phase_hi) begin
              sclk     <= 1'b1;
              phase_hi <= 1'b1;
              rx_sr    <= {rx_sr[6:0], miso};
              if (bit_cnt == 3'd7 && byte_idx != '0 && is_read)
                rx_done <= 1'b1;
            end else begin
              phase_hi <= 1'b0;
              if (bit_cnt != 3'd7) begin
                sclk    <= 1'b0;
                bit_cnt <= bit_cnt + 1'b1;
                mosi    <= tx_sr[6];
                tx_sr   <= {tx_sr[6:0], 1'b1};
              end else if (byte_idx != len_q) begin
                sclk     <= 1'b0;
                bit_cnt  <= 3'd0;
                byte_idx <= byte_idx + 1'b1;
                tx_sr    <= next_byte;
                mosi     <= next_byte[7];
`ifdef SPI_MPU_WRITE_EN
                wdata_req <= !rw_q && ((byte_idx + 1'b1) < len_q);
`endif
              end else begin
                mosi  <= 1'b1;
                state <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cs_n   <= 1'b1;
            busy   <= 1'b0;
            finish <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mpu_burst.sv
// Self-checking bench for spi_mpu_burst with a mode-3 MPU slave model and byte scoreboards.
// Exercises the write path when SPI_MPU_WRITE_EN is defined, the forced-read path otherwise.
module tb_spi_mpu_burst;
  logic       clk = 1'b0;
  logic       rst, start, rw, miso;
  logic [6:0] addr;
  logic [3:0] len;
  logic [7:0] wdata;
  logic       sclk, cs_n, mosi, busy, finish, rdata_valid, wdata_req;
  logic [7:0] rdata;

  int checks = 0;
  int errors = 0;
  int cyc_now = 0, fin_cnt = 0, rdv_cnt = 0, wreq_cnt = 0, sclk_bad = 0;
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rd[$];
  logic [7:0] resp_q[$];
  logic [7:0] wq[$];
  int rdv_times[$];
  int m_bit = 0;
  logic [7:0] m_rx = 8'h00, m_tx = 8'h00;
  logic [31:0] exp_b, exp_r;

  spi_mpu_burst #(.CLK_DIV(4), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .miso(miso), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .busy(busy), .finish(finish), .rdata(rdata), .rdata_valid(rdata_valid),
    .wdata_req(wdata_req)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MPU slave: shifts out response bytes on sclk fall, captures mosi on sclk rise
  always @(negedge cs_n) m_bit = 0;

  always @(negedge sclk) begin
    if (cs_n === 1'b0 && rst === 1'b0) begin
      if (m_bit % 8 == 0) begin
        m_tx = 8'h00;
        if (m_bit >= 8 && resp_q.size() > 0) m_tx = resp_q.pop_front();
      end
      miso = m_tx[7 - (m_bit % 8)];
    end
  end

  always @(posedge sclk) begin
    if (cs_n === 1'b0 && rst === 1'b0) begin
      m_rx = {m_rx[6:0], mosi};
      m_bit++;
      if (m_bit % 8 == 0) begin
        exp_b = 32'hFFFF_FFFF;
        if (exp_mosi.size() > 0) exp_b = {24'h0, exp_mosi.pop_front()};
        check("mosi_byte", {24'h0, m_rx}, exp_b);
      end
    end
  end

  always @(negedge clk) begin
    cyc_now++;
    if (finish === 1'b1) fin_cnt++;
    if (cs_n === 1'b1 && sclk !== 1'b1) sclk_bad++;
    if (wdata_req === 1'b1) begin
      wreq_cnt++;
      wdata = (wq.size() > 0) ? wq.pop_front() : 8'h00;
    end
    if (rdata_valid === 1'b1) begin
      rdv_cnt++;
      rdv_times.push_back(cyc_now);
      exp_r = 32'hFFFF_FFFF;
      if (exp_rd.size() > 0) exp_r = {24'h0, exp_rd.pop_front()};
      check("rdata", {24'h0, rdata}, exp_r);
    end
  end

  // counts busy cycles; returns on the first busy=0 negedge (or right after a reset poke)
  task automatic wait_busy(input int poke_at, input logic poke_rst, output int cyc);
    cyc = 1;
    forever begin
      if (cyc == poke_at) begin
        if (poke_rst) begin
          rst = 1'b1;
          return;
        end
        start = 1'b1;
        addr  = 7'h00;
        len   = 4'hF;
        rw    = ~rw;
      end
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1 || cyc >= 3000) break;
      cyc++;
    end
  endtask

  task automatic do_txn(input logic rw_i, input logic [6:0] a, input logic [3:0] l,
                        input int poke_at, input logic poke_rst, output int cyc);
    rw = rw_i; addr = a; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1'b1);
    check("cs_n_fall", cs_n, 1'b0);
    wait_busy(poke_at, poke_rst, cyc);
  endtask

  task automatic txn_end(input int f0, input int r0, input int w0, input int n_rdv, input int n_wreq);
    check("finish_at_busy_fall", {finish, cs_n}, 2'b11);
    @(negedge clk);
    #1;
    check("finish_one_cycle", finish, 1'b0);
    check("finish_count", fin_cnt - f0, 1);
    check("rdv_count", rdv_cnt - r0, n_rdv);
    check("wreq_count", wreq_cnt - w0, n_wreq);
  endtask

  function automatic logic [7:0] hdr(input logic rw_i, input logic [6:0] a);
`ifdef SPI_MPU_WRITE_EN
    return {rw_i, a};
`else
    return {1'b1, a};
`endif
  endfunction

  initial begin
    int cyc, f0, r0, w0;
    rst = 1'b1; start = 1'b0; rw = 1'b1; addr = 7'h00; len = 4'd1; wdata = 8'h00; miso = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {sclk, cs_n, mosi, busy, finish, rdata_valid, wdata_req}, 7'b1110000);
    check("reset_rdata", rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // single read
    exp_mosi.push_back(8'hB7); exp_mosi.push_back(8'hFF);
    resp_q.push_back(8'hA5); exp_rd.push_back(8'hA5);
    f0 = fin_cnt; r0 = rdv_cnt; w0 = wreq_cnt;
    do_txn(1'b1, 7'h37, 4'd1, 0, 1'b0, cyc);
    check("single_busy_len", cyc, 136);
    txn_end(f0, r0, w0, 1, 0);
    check("single_rdata_hold", rdata, 8'hA5);

    // burst read of six bytes
    exp_mosi.push_back(8'hBB);
    for (int i = 0; i < 6; i++) begin
      exp_mosi.push_back(8'hFF);
      resp_q.push_back(8'h10 + 8'(i));
      exp_rd.push_back(8'h10 + 8'(i));
    end
    rdv_times.delete();
    f0 = fin_cnt; r0 = rdv_cnt; w0 = wreq_cnt;
    do_txn(1'b1, 7'h3B, 4'd6, 0, 1'b0, cyc);
    check("burst_busy_len", cyc, 456);
    txn_end(f0, r0, w0, 6, 0);
    for (int i = 1; i < rdv_times.size(); i++)
      check("burst_rdv_spacing", rdv_times[i] - rdv_times[i-1], 64);

`ifdef SPI_MPU_WRITE_EN
    exp_mosi.push_back(8'h6B); exp_mosi.push_back(8'h80); exp_mosi.push_back(8'h01);
    wq.push_back(8'h80); wq.push_back(8'h01);
    f0 = fin_cnt; r0 = rdv_cnt; w0 = wreq_cnt;
    do_txn(1'b0, 7'h6B, 4'd2, 0, 1'b0, cyc);
    check("write_busy_len", cyc, 200);
    txn_end(f0, r0, w0, 0, 2);
`else
    wdata = 8'h55;
    exp_mosi.push_back(8'hEB); exp_mosi.push_back(8'hFF);
    resp_q.push_back(8'h9E); exp_rd.push_back(8'h9E);
    f0 = fin_cnt; r0 = rdv_cnt; w0 = wreq_cnt;
    do_txn(1'b0, 7'h6B, 4'd1, 0, 1'b0, cyc);
    check("wrdis_busy_len", cyc, 136);
    txn_end(f0, r0, w0, 1, 0);
`endif

    // start and input changes mid-burst are ignored
    exp_mosi.push_back(hdr(1'b1, 7'h22)); exp_mosi.push_back(8'hFF); exp_mosi.push_back(8'hFF);
    resp_q.push_back(8'h3C); resp_q.push_back(8'hC3);
    exp_rd.push_back(8'h3C); exp_rd.push_back(8'hC3);
    f0 = fin_cnt; r0 = rdv_cnt; w0 = wreq_cnt;
    do_txn(1'b1, 7'h22, 4'd2, 50, 1'b0, cyc);
    check("poke_busy_len", cyc, 200);
    txn_end(f0, r0, w0, 2, 0);

    // len=0 behaves as one byte; start during the finish cycle is ignored
    exp_mosi.push_back(8'hB7); exp_mosi.push_back(8'hFF);
    resp_q.push_back(8'h42); exp_rd.push_back(8'h42);
    r0 = rdv_cnt;
    do_txn(1'b1, 7'h37, 4'd0, 0, 1'b0, cyc);
    check("len0_busy_len", cyc, 136);
    check("len0_finish", finish, 1'b1);
    check("len0_rdv_count", rdv_cnt - r0, 1);
    exp_mosi.push_back(8'hB7); exp_mosi.push_back(8'hFF);
    resp_q.push_back(8'h66); exp_rd.push_back(8'h66);
    rw = 1'b1; addr = 7'h37; len = 4'd1; start = 1'b1;
    @(negedge clk);
    check("start_on_finish_ignored", busy, 1'b0);
    f0 = fin_cnt; r0 = rdv_cnt; w0 = wreq_cnt;
    @(negedge clk);
    start = 1'b0;
    check("start_after_finish_accepted", busy, 1'b1);
    wait_busy(0, 1'b0, cyc);
    check("restart_busy_len", cyc, 136);
    txn_end(f0, r0, w0, 1, 0);

    // reset during bit 3 of data byte 2
    exp_mosi.push_back(8'h90);
    for (int i = 0; i < 3; i++) exp_mosi.push_back(8'hFF);
    resp_q.push_back(8'h77); resp_q.push_back(8'h88); resp_q.push_back(8'h99);
    exp_rd.push_back(8'h77); exp_rd.push_back(8'h88); exp_rd.push_back(8'h99);
    f0 = fin_cnt; r0 = rdv_cnt;
    do_txn(1'b1, 7'h10, 4'd3, 160, 1'b1, cyc);
    #1;
    check("midrst_ctrl", {sclk, cs_n, mosi, busy, finish, rdata_valid, wdata_req}, 7'b1110000);
    check("midrst_rdata", rdata, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("midrst_no_finish", fin_cnt - f0, 0);
    check("midrst_rdv_byte1_only", rdv_cnt - r0, 1);
    check("midrst_rdata_after", rdata, 8'h00);
    check("midrst_idle", {cs_n, busy}, 2'b10);
    exp_mosi.delete(); exp_rd.delete(); resp_q.delete();

    // normal read after reset
    exp_mosi.push_back(8'hB7); exp_mosi.push_back(8'hFF);
    resp_q.push_back(8'h5C); exp_rd.push_back(8'h5C);
    f0 = fin_cnt; r0 = rdv_cnt; w0 = wreq_cnt;
    do_txn(1'b1, 7'h37, 4'd1, 0, 1'b0, cyc);
    check("postrst_busy_len", cyc, 136);
    txn_end(f0, r0, w0, 1, 0);

    check("sclk_high_when_cs_n_high", sclk_bad, 0);
    check("mosi_bytes_all_seen", exp_mosi.size(), 0);
    check("rdata_bytes_all_seen", exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
